knns_sorted_seq_td: RTL and testbench
=====================================

# knns_sorted_seq_td

Sequential k-nearest-neighbour stage that generalises the single-minimum taxicab search to the K nearest points. Each cycle with `e_valid` high, it computes the taxicab distance between the garbler query point and the incoming evaluator point. It then inserts the evaluator point into a K-entry list kept sorted by distance. The list feeds the downstream vote/label stage of the kNN classifier, and with K=1 it reduces to the first-nearest-neighbour search.

## Interface
- `W`, 15, coordinate width in bits; a point is `{x, y}`, each W bits.
- `K`, 4, number of neighbours kept (K ≥ 1).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `g_input` input 2W: query point `{x2, y2}`; held constant for the whole query.
- `e_input` input 2W: candidate point `{x1, y1}`.
- `e_valid` input 1: `e_input` is a candidate this cycle.
- `o` output 2·K·W: sorted neighbour list; slot i is `o[2W·i +: 2W]`, and slot 0 is the nearest.
- `o_dist` output K·(W+2): distance for each slot; slot i is `o_dist[(W+2)·i +: W+2]`.
- `cnt` output `log2(K)` bits: number of occupied slots, saturating at K. `log2` is the codebase ceiling-bit-count function.

## Operation
- Distance: `dist = |x1−x2| + |y1−y2|`, unsigned, zero-extended to W+2 bits. The maximum is 2^(W+1)−2, which never reaches the empty sentinel.
- State: K point registers `pt[i]` (2W bits) and K distance registers `dr[i]` (W+2 bits).
- Invariant: `dr[0] ≤ dr[1] ≤ … ≤ dr[K−1]`.
- Empty slot: `pt = 0`, `dr` = all ones.
- Per-slot compare: `lt[i] = (dist < dr[i])`, strict.
  - Because the list is sorted, `lt` is monotone: once a slot compares true, every higher slot does too.
  - Define `lt[−1] = 0`.
- Update on a cycle with `e_valid = 1`, for each i:
  - if `lt[i] = 0`: slot i holds its value.
  - else if `lt[i−1] = 1`: slot i takes slot i−1 (shift down).
  - else: slot i takes `{e_input, dist}` (insert).
  - The previous slot K−1 is discarded when a shift reaches it.
- Ties: a new point with distance equal to an existing entry is placed after it, so the earlier arrival wins.
- A candidate with `dist ≥ dr[K−1]` leaves the list unchanged.
- `cnt` increments by 1 on every valid cycle while `cnt < K`, then holds at K. This happens regardless of whether an insert occurred, since an empty slot always accepts.
- With `e_valid = 0` all state holds.
- `g_input` is not registered. If it changes mid-query, stored distances go stale. The system must assert `rst` between queries.
- No comparator or mux is shared across slots: K parallel comparators and K 2-way muxes, all single-cycle.

## Timing
- Reset: all `pt` = 0, all `dr` = {W+2{1'b1}}, `cnt` = 0. `o`, `o_dist` and `cnt` show these values immediately, asynchronously.
- `o`, `o_dist` and `cnt` are registered outputs, not combinational. A candidate presented at edge n is visible after edge n.
  - Latency is 1 cycle.
  - Throughput is 1 candidate per cycle, back-to-back, with no stall.
- Reset asserted mid-stream clears the list at once. The first valid candidate after deassertion is treated as the first of a new query.
- `e_valid` and `rst` both high: reset wins and the candidate is dropped.

## Test plan
- **Reset:** assert `rst`, W=15, K=4 → `cnt` = 0; every `o_dist` slot = 0x1FFFF; `o` = 0.
- **Ascending fill:** `g_input` = {100, 100}; stream e = {101,100}, {103,100}, {100,110}, {150,150} → after 4 cycles `o_dist` = 1, 3, 10, 100 in slots 0–3; `cnt` = 4.
- **Reverse order with overflow:**
  - Same query; stream distances 100, 10, 3, 1 → after 4 cycles, slots 0–3 = 1, 3, 10, 100, in that order.
  - Then present e = {100,100}: dist 0 → slots become 0, 1, 3, 10; the dist-100 point is dropped; `cnt` stays 4.
- **Tie and reject:**
  - With slots at 1, 3, 10, 100, present e = {102,101} (dist 3) → slots become 1, 3(old), 3(new), 10; slot 1 still holds the original point.
  - Then present dist 200 → no change.
- **Gaps:** toggle `e_valid` 1-0-0-1 with distinct points → state holds on the idle cycles; `cnt` = 2.
- **Mid-stream reset:** assert `rst` asynchronously mid-cycle after 3 inserts → outputs return to reset values before the next edge. Then stream one point at dist 7 → slot 0 = 7, `cnt` = 1.

Source files
------------

// File: rtl/knns_sorted_seq_td.sv
// Sequential k-nearest-neighbour stage: streams evaluator points against one query
// point and keeps the K nearest, sorted by taxicab distance, in registers.
module knns_sorted_seq_td #(
    parameter  int W  = 15,
    parameter  int K  = 4,
    localparam int DW = W + 2,
    localparam int CW = $clog2(K + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*W-1:0]    g_input,
    input  logic [2*W-1:0]    e_input,
    input  logic              e_valid,
    output logic [2*K*W-1:0]  o,
    output logic [K*DW-1:0]   o_dist,
    output logic [CW-1:0]     cnt
);

    logic [W-1:0]              w_x1, w_y1, w_x2, w_y2;
    logic [W-1:0]              w_dx, w_dy;
    logic [DW-1:0]             w_dist;
    logic [K-1:0]              w_lt, w_lt_up;
    logic [K-1:0][2*W-1:0]     r_pt, w_pt_up;
    logic [K-1:0][DW-1:0]      r_dr, w_dr_up;
    logic [CW-1:0]             r_cnt;

    assign w_x1 = e_input[2*W-1:W];
    assign w_y1 = e_input[W-1:0];
    assign w_x2 = g_input[2*W-1:W];
    assign w_y2 = g_input[W-1:0];

    assign w_dx   = (w_x1 >= w_x2) ? (w_x1 - w_x2) : (w_x2 - w_x1);
    assign w_dy   = (w_y1 >= w_y2) ? (w_y1 - w_y2) : (w_y2 - w_y1);
    assign w_dist = DW'(w_dx) + DW'(w_dy);

    // Strict compare keeps an equal-distance newcomer behind the earlier arrival.
    always_comb begin
        // NOTE: default first so no path through the block leaves w_lt unassigned (no latch).
        w_lt = '0;
        for (int i = 0; i < K; i++) begin
            w_lt[i] = (w_dist < r_dr[i]);
        end
    end

    // Slot i sees slot i-1 through these; slot 0 gets lt=0, so it never shifts.
    assign w_lt_up = w_lt << 1;
    assign w_pt_up = r_pt << (2 * W);
    assign w_dr_up = r_dr << DW;

    // NOTE: the slot registers are reset, not left uninitialised: the all-ones
    // distance is the empty marker that makes any first candidate insert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pt  <= '0;
            r_dr  <= '1;
            r_cnt <= '0;
        end else if (e_valid) begin
            // NOTE: non-blocking so every slot shifts from the pre-edge list, not a half-updated one.
            for (int i = 0; i < K; i++) begin
                if (w_lt[i]) begin
                    r_pt[i] <= w_lt_up[i] ? w_pt_up[i] : e_input;
                    r_dr[i] <= w_lt_up[i] ? w_dr_up[i] : w_dist;
                end
            end
            if (r_cnt < CW'(K)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o      = r_pt;
    assign o_dist = r_dr;
    assign cnt    = r_cnt;

endmodule

// File: tb/tb_knns_sorted_seq_td.sv
// Scoreboard bench for knns_sorted_seq_td (W=15, K=4): directed points with
// hand-computed sorted lists, checked by a monitor decoupled from the stimulus.
module tb_knns_sorted_seq_td;

    localparam int W  = 15;
    localparam int K  = 4;
    localparam int DW = W + 2;
    localparam int PW = 2 * W;
    localparam int CW = $clog2(K + 1);
    localparam logic [DW-1:0] EM = '1;
    localparam logic [PW-1:0] NP = '0;

    logic              clk = 1'b0;
    logic              rst;
    logic [PW-1:0]     g_input;
    logic [PW-1:0]     e_input;
    logic              e_valid;
    logic [2*K*W-1:0]  o;
    logic [K*DW-1:0]   o_dist;
    logic [CW-1:0]     cnt;

    knns_sorted_seq_td #(.W(W), .K(K)) dut (
        .clk     (clk),
        .rst     (rst),
        .g_input (g_input),
        .e_input (e_input),
        .e_valid (e_valid),
        .o       (o),
        .o_dist  (o_dist),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*K*W-1:0] o;
        logic [K*DW-1:0]  d;
        logic [CW-1:0]    c;
        int               due;
        string            tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc++;

    function automatic logic [PW-1:0] pt(input int x, input int y);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        return {xv[W-1:0], yv[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [2*K*W-1:0] act, input logic [2*K*W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input string tag, input int due,
                        input logic [PW-1:0] p0, p1, p2, p3,
                        input logic [DW-1:0] d0, d1, d2, d3, input int c);
        exp_t e;
        e.o   = {p3, p2, p1, p0};
        e.d   = {d3, d2, d1, d0};
        e.c   = CW'(c);
        e.due = due;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every expectation once the edge it targets has happened.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check({e.tag, ".o"},      o,      {{(2*K*W){1'b0}}} | e.o);
                check({e.tag, ".o_dist"}, {{(2*K*W-K*DW){1'b0}}, o_dist}, {{(2*K*W-K*DW){1'b0}}, e.d});
                check({e.tag, ".cnt"},    {{(2*K*W-CW){1'b0}}, cnt},      {{(2*K*W-CW){1'b0}}, e.c});
            end
        end
    end

    task automatic step(input string tag, input logic v, input logic [PW-1:0] e,
                        input logic [PW-1:0] p0, p1, p2, p3,
                        input logic [DW-1:0] d0, d1, d2, d3, input int c);
        e_valid = v;
        e_input = e;
        push(tag, cyc + 1, p0, p1, p2, p3, d0, d1, d2, d3, c);
        @(posedge clk);
        #1;
        e_valid = 1'b0;
    endtask

    // Asynchronous reset between edges, held across one edge with a live candidate.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2;
        e_valid = 1'b1;
        e_input = pt(150, 150);
        push({tag, "_async"}, cyc, NP, NP, NP, NP, EM, EM, EM, EM, 0);
        push({tag, "_wins"}, cyc + 1, NP, NP, NP, NP, EM, EM, EM, EM, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        e_valid = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] a, b, c, d, z, t, r, s, g, p, m;
        a = pt(101, 100);   // dist 1
        b = pt(103, 100);   // dist 3
        c = pt(100, 110);   // dist 10
        d = pt(150, 150);   // dist 100
        z = pt(100, 100);   // dist 0
        t = pt(102, 101);   // dist 3 (tie with b)
        r = pt(200, 200);   // dist 200
        s = pt(105, 105);   // dist 10 (tie with last slot)
        g = pt(90, 95);     // dist 15
        p = pt(104, 103);   // dist 7
        m = pt(0, 32767);   // dist 100 + 32667 = 32767

        rst     = 1'b0;
        e_valid = 1'b0;
        e_input = '0;
        g_input = pt(100, 100);
        #1;
        push("reset", cyc, NP, NP, NP, NP, EM, EM, EM, EM, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step("asc1", 1'b1, a, a, NP, NP, NP, 17'd1, EM, EM, EM, 1);
        step("asc2", 1'b1, b, a, b, NP, NP, 17'd1, 17'd3, EM, EM, 2);
        step("asc3", 1'b1, c, a, b, c, NP, 17'd1, 17'd3, 17'd10, EM, 3);
        step("asc4", 1'b1, d, a, b, c, d, 17'd1, 17'd3, 17'd10, 17'd100, 4);

        reset_pulse("rst1");
        step("rev1", 1'b1, d, d, NP, NP, NP, 17'd100, EM, EM, EM, 1);
        step("rev2", 1'b1, c, c, d, NP, NP, 17'd10, 17'd100, EM, EM, 2);
        step("rev3", 1'b1, b, b, c, d, NP, 17'd3, 17'd10, 17'd100, EM, 3);
        step("rev4", 1'b1, a, a, b, c, d, 17'd1, 17'd3, 17'd10, 17'd100, 4);
        step("ovfl", 1'b1, z, z, a, b, c, 17'd0, 17'd1, 17'd3, 17'd10, 4);

        reset_pulse("rst2");
        step("tf1", 1'b1, a, a, NP, NP, NP, 17'd1, EM, EM, EM, 1);
        step("tf2", 1'b1, b, a, b, NP, NP, 17'd1, 17'd3, EM, EM, 2);
        step("tf3", 1'b1, c, a, b, c, NP, 17'd1, 17'd3, 17'd10, EM, 3);
        step("tf4", 1'b1, d, a, b, c, d, 17'd1, 17'd3, 17'd10, 17'd100, 4);
        step("tie", 1'b1, t, a, b, t, c, 17'd1, 17'd3, 17'd3, 17'd10, 4);
        step("rej200", 1'b1, r, a, b, t, c, 17'd1, 17'd3, 17'd3, 17'd10, 4);
        step("rejeq", 1'b1, s, a, b, t, c, 17'd1, 17'd3, 17'd3, 17'd10, 4);

        reset_pulse("rst3");
        step("gap1", 1'b1, a, a, NP, NP, NP, 17'd1, EM, EM, EM, 1);
        step("gap2", 1'b0, b, a, NP, NP, NP, 17'd1, EM, EM, EM, 1);
        step("gap3", 1'b0, z, a, NP, NP, NP, 17'd1, EM, EM, EM, 1);
        step("gap4", 1'b1, g, a, g, NP, NP, 17'd1, 17'd15, EM, EM, 2);

        reset_pulse("rst4");
        step("mid1", 1'b1, c, c, NP, NP, NP, 17'd10, EM, EM, EM, 1);
        step("mid2", 1'b1, a, a, c, NP, NP, 17'd1, 17'd10, EM, EM, 2);
        step("mid3", 1'b1, b, a, b, c, NP, 17'd1, 17'd3, 17'd10, EM, 3);
        reset_pulse("midrst");
        step("post1", 1'b1, p, p, NP, NP, NP, 17'd7, EM, EM, EM, 1);
        step("post2", 1'b1, m, p, m, NP, NP, 17'd7, 17'd32767, EM, EM, 2);

        repeat (2) @(posedge clk);
        #6;
        check("scoreboard_drained", {{(2*K*W-32){1'b0}}, 32'(exp_q.size())}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
